// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: result-select,
// forwarding mux selects and the memory-wait state machine states.
package hazard_ctrl_pkg;

  localparam logic [1:0] RESULT_LOAD = 2'b01;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forwarding select for one ALU operand in EX. The youngest producer
// (MEM) has priority over WB, and x0 is never forwarded.
module hazard_ctrl_fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] m_rf_a3,
  input  logic       m_we_rf,
  input  logic [4:0] w_rf_a3,
  input  logic       w_we_rf,
  output logic [1:0] fwd
);

  always_comb begin
    fwd = FWD_RF;
    if (rs != 5'd0) begin
      if (m_we_rf && (m_rf_a3 == rs)) begin
        fwd = FWD_MEM;
      end else if (w_we_rf && (w_rf_a3 == rs)) begin
        fwd = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/clear/forward generation for the
// five-stage core plus a timed data-memory wait FSM and perf counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       D_rs1,
  input  logic [4:0]       D_rs2,
  input  logic [4:0]       E_rs1,
  input  logic [4:0]       E_rs2,
  input  logic [4:0]       E_rf_a3,
  input  logic [1:0]       E_sel_result,
  input  logic             E_pc_src,
  input  logic [4:0]       M_rf_a3,
  input  logic [4:0]       W_rf_a3,
  input  logic             M_we_rf,
  input  logic             W_we_rf,
  input  logic             M_mem_req,
  input  logic             M_mem_ready,
  output logic             F_stall,
  output logic             D_stall,
  output logic             E_stall,
  output logic             M_stall,
  output logic             D_clr,
  output logic             E_clr,
  output logic             W_clr,
  output logic [1:0]       E_fwd_a,
  output logic [1:0]       E_fwd_b,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state;
  state_t            state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout_hit;
  logic              load_use;
  logic              mem_hold;
  logic              flush;
  logic              lu_stall;

  hazard_ctrl_fwd_sel u_fwd_a (
    .rs      (E_rs1),
    .m_rf_a3 (M_rf_a3),
    .m_we_rf (M_we_rf),
    .w_rf_a3 (W_rf_a3),
    .w_we_rf (W_we_rf),
    .fwd     (E_fwd_a)
  );

  hazard_ctrl_fwd_sel u_fwd_b (
    .rs      (E_rs2),
    .m_rf_a3 (M_rf_a3),
    .m_we_rf (M_we_rf),
    .w_rf_a3 (W_rf_a3),
    .w_we_rf (W_we_rf),
    .fwd     (E_fwd_b)
  );

  assign timeout_hit = (wait_cnt == WAIT_LAST);
  assign load_use    = (E_sel_result == RESULT_LOAD) && (E_rf_a3 != 5'd0) &&
                       ((E_rf_a3 == D_rs1) || (E_rf_a3 == D_rs2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:      if (M_mem_req && !M_mem_ready) state_next = MEM_WAIT;
      MEM_WAIT: if (M_mem_ready || timeout_hit) state_next = RUN;
      default:  state_next = RUN;
    endcase
  end

  // The entry cycle already holds the pipeline, so MEM never advances
  // before the wait is established; branch and load-use are masked then.
  always_comb begin
    mem_hold = 1'b0;
    flush    = 1'b0;
    lu_stall = 1'b0;
    if (!rst) begin
      mem_hold = (state == MEM_WAIT) || (M_mem_req && !M_mem_ready);
      flush    = !mem_hold && E_pc_src;
      lu_stall = !mem_hold && load_use && !E_pc_src;
    end
    F_stall = mem_hold || lu_stall;
    D_stall = mem_hold || lu_stall;
    E_stall = mem_hold;
    M_stall = mem_hold;
    W_clr   = mem_hold;
    D_clr   = flush;
    E_clr   = flush || lu_stall;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      if (state == RUN) begin
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if ((state == MEM_WAIT) && !M_mem_ready && timeout_hit) begin
        mem_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (F_stall) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush)   flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage pipelined core. Combinationally produces stall, clear and forwarding selects for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and sequences a multi-cycle data-memory wait through a small state machine with a timeout. Also keeps stall and flush event counters for performance debug. Sits beside the datapath and drives every pipeline register's enable and clear.

## Interface
Parameters:
- MEM_TIMEOUT, 16: maximum cycles in MEM_WAIT before abort (≥2).
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- D_rs1, D_rs2  in  5 each  source registers of the instruction in ID.
- E_rs1, E_rs2  in  5 each  source registers of the instruction in EX.
- E_rf_a3  in  5  destination of the instruction in EX.
- E_sel_result  in  2  result select in EX; 2'b01 = load.
- E_pc_src  in  1  branch taken or jump resolved in EX.
- M_rf_a3, W_rf_a3  in  5 each  destinations in MEM and WB.
- M_we_rf, W_we_rf  in  1 each  register write enables in MEM and WB.
- M_mem_req  in  1  load or store active in MEM.
- M_mem_ready  in  1  data memory completes the MEM access this cycle.
- F_stall, D_stall, E_stall, M_stall  out  1 each  hold PC / IF/ID / ID/EX / EX/MEM.
- D_clr, E_clr, W_clr  out  1 each  synchronous bubble into IF/ID, ID/EX, MEM/WB.
- E_fwd_a, E_fwd_b  out  2 each  ALU operand select: 00 register file, 10 MEM result, 01 WB result.
- mem_err  out  1  sticky: a MEM access timed out.
- stall_cnt, flush_cnt  out  CNT_W each  stall cycles / flush events since reset.

## Operation
- States: RUN, MEM_WAIT. Reset state RUN.
- RUN -> MEM_WAIT: M_mem_req=1 and M_mem_ready=0. MEM_WAIT -> RUN: M_mem_ready=1, or wait counter reaches MEM_TIMEOUT-1 (then set mem_err).
- MEM_WAIT outputs: F_stall=D_stall=E_stall=M_stall=1, W_clr=1, D_clr=E_clr=0. Branch/load-use logic suppressed.
- The entry cycle (RUN, req=1, ready=0) itself drives the MEM_WAIT outputs combinationally, so no instruction advances past MEM.
- Load-use (RUN only): E_sel_result=01, E_rf_a3≠0, E_rf_a3 equals D_rs1 or D_rs2 -> F_stall=D_stall=1, E_clr=1.
- Control hazard (RUN only): E_pc_src=1 -> D_clr=E_clr=1, no stalls. If load-use holds in the same cycle, flush wins: no stall.
- Forwarding, per operand: rs=0 -> 00; M_we_rf and M_rf_a3=rs -> 10; else W_we_rf and W_rf_a3=rs -> 01; else 00. MEM wins over WB. Active in every state.
- stall_cnt: +1 each cycle F_stall=1. flush_cnt: +1 each cycle E_pc_src causes a flush. Both wrap modulo 2^CNT_W.
- Wait counter cleared on entry to MEM_WAIT; mem_err cleared only by rst.

## Timing
- Stall/clear/forward outputs combinational from inputs and state; zero latency.
- State, wait counter, mem_err and performance counters update on rising clk.
- Async rst: state=RUN, wait counter=0, mem_err=0, stall_cnt=0, flush_cnt=0. While rst=1, all stall/clear outputs forced 0; E_fwd_a/E_fwd_b follow the forwarding rules.
- M_mem_ready=1 in the first cycle of M_mem_req: no stall, state stays RUN.
- Timeout: exit on the cycle the counter equals MEM_TIMEOUT-1. mem_err visible the next cycle. The pipeline resumes with the access treated as done.
- rst mid-MEM_WAIT: immediate return to RUN, no mem_err.

## Structure
- Shared package holds: RESULT_LOAD=2'b01; forwarding encodings FWD_RF/FWD_MEM/FWD_WB; state enum.
- Natural sub-module: fwd_sel, instantiated twice (one per operand).
- Counters and FSM stay inline.

## Test plan
- Forward: E_rs1=5, M_we_rf=1, M_rf_a3=5, W_we_rf=1, W_rf_a3=5 -> E_fwd_a=10. E_rs2=0 with M_rf_a3=0 -> E_fwd_b=00.
- Load-use: E_sel_result=01, E_rf_a3=7, D_rs2=7 -> F_stall=D_stall=E_clr=1 for one cycle, stall_cnt 0->1. Add E_pc_src=1 in that cycle -> no stall, D_clr=E_clr=1, flush_cnt=1.
- Mem wait: M_mem_req=1, ready low 3 cycles then high -> F/D/E/M_stall and W_clr high 4 cycles, state back to RUN, stall_cnt=4.
- Timeout: MEM_TIMEOUT=4, ready never high -> exit after 4 cycles, mem_err=1 and held until rst.
- Reset mid-wait: assert rst in cycle 2 of MEM_WAIT -> all stalls drop at once; counters=0, mem_err=0.
- Branch during MEM_WAIT: E_pc_src=1 while waiting -> D_clr=E_clr=0, flush_cnt unchanged until the state returns to RUN.
